sc_bitstream_encoder: RTL and testbench
=======================================

Name: sc_bitstream_encoder

Overview:
Converts unsigned binary values (e.g. MNIST pixel intensities) into N parallel unipolar stochastic bitstreams. It is the front end that feeds the `din` bitstream bus of the SC APC neuron network.
One shared random-number source and N comparators produce one stream bit per channel per cycle, over a frame of 2^W cycles.
A start/busy/done handshake frames each encode operation. An enable input lets the downstream network stall the stream.

Parameters:
N, 784, number of channels (bitstream width of dout).
W, 8, value width in bits; frame length is 2^W cycles; supported range 4..16.
RNG_MODE, 0, 0 = bit-reversed counter (exact, low-discrepancy); 1 = W-bit maximal-length Fibonacci LFSR.
SEED, 1, LFSR initial value in RNG_MODE 1; must be non-zero (zero is replaced by 1).

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request to encode; sampled only in IDLE.
value  input  W x [0:N-1]  per-channel binary value, captured on an accepted start.
en  input  1  stream advance enable (downstream ready); low = stall.
dout  output  N  stochastic bits, one per channel.
dout_valid  output  1  dout carries a valid stream bit this cycle.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse after the last stream bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: busy=0, done=0, dout_valid=0, dout=0.
  - State: state=IDLE, cnt=0, value_q=0, LFSR=SEED.
  - Reset mid-RUN aborts the frame immediately; no done pulse is produced.
- States: IDLE, RUN. `done` is a registered flag, not a separate state.
- IDLE:
  - On a rising edge with start=1: value_q[i] <= value[i] for all i; cnt <= 0; LFSR <= SEED; state <= RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - dout_valid = en (combinational).
  - dout[i] = en & (value_q[i] > rnd), unsigned W-bit compare.
  - When en=0: dout=0, and cnt, LFSR and state all hold.
- Random source:
  - RNG_MODE 0: rnd = bit-reverse(cnt).
  - RNG_MODE 1: rnd = LFSR state.
  - Both advance only on cycles where RUN & en.
  - LFSR taps for W=8: x^8+x^6+x^5+x^4+1. A fixed maximal-length tap table covers W=4..16.
- Frame length:
  - Exactly 2^W valid cycles; cnt is W+1 bits or wraps with a last flag.
  - On the edge where RUN & en & cnt==2^W-1: state <= IDLE and done <= 1.
  - done deasserts on the following edge.
- Start during RUN is ignored; no queuing.
- Start in the cycle done is high is legal: state is already IDLE, so it is accepted and a new RUN begins on that edge.
- value may change freely after capture; only value_q drives the comparators.
- Latency:
  - The first valid bit appears in the first cycle after the accepting edge (when en=1).
  - done rises one cycle after the last valid bit.
- Exactness:
  - RNG_MODE 0: over a full frame, the count of ones on dout[i] equals value_q[i] exactly.
  - value 0 → all zeros; value 2^W-1 → 2^W-1 ones.
  - RNG_MODE 1: the count is within ±1 of value_q[i].
- All channels share rnd; inter-channel correlation is intentional. Weight streams use independent sources outside this block.

Test Plan:
1. Exact counts: RNG_MODE 0, W=8, N=4, value={0,255,128,37}, start pulse, en=1 → exactly 256 dout_valid cycles with ones counts {0,255,128,37}; busy high for 256 cycles; done a single pulse on cycle 257.
2. Bit order: value[0]=128 in RNG_MODE 0 → first four valid bits 1,0,1,0 (rnd=0,128,64,192).
3. Stall: drop en for 10 cycles mid-frame → dout=0 and dout_valid=0 during the stall; counts still exact; done delayed by 10 cycles.
4. Protocol: start reasserted during RUN and value changed → no restart, counts match the originally captured values; start held high through done → new frame begins immediately after done with no idle gap.
5. Reset mid-RUN: assert reset=0 asynchronously at bit 100 → busy, dout_valid, dout and done drop to 0 without waiting for a clock; no done pulse; a subsequent start runs a full 256-cycle frame.
6. LFSR mode: RNG_MODE 1, SEED=8'h01, value=64 → 256 valid cycles with 63..65 ones; LFSR never reaches 0; frame repeatable bit-for-bit across two starts.

Source files
------------

// File: rtl/sc_bitstream_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sc_bitstream_encoder
//  Description : Converts N unsigned W-bit values into N parallel unipolar
//                stochastic bitstreams over a frame of 2^W valid cycles.
//                One shared random source (bit-reversed counter or LFSR)
//                feeds N magnitude comparators. A start/busy/done handshake
//                frames each encode; en stalls the stream.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous, active-low reset
//                start      - encode request, sampled only in IDLE
//                value      - N x W packed values, channel i at [i*W +: W]
//                en         - stream advance enable (downstream ready)
//                dout       - N stochastic bits, one per channel
//                dout_valid - dout carries a valid stream bit this cycle
//                busy       - high while a frame is running
//                done       - one-cycle pulse after the last stream bit
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_bitstream_encoder #(
    parameter int N        = 784,
    parameter int W        = 8,
    parameter int RNG_MODE = 0,
    parameter int SEED     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N*W-1:0]   value,
    input  logic             en,
    output logic [N-1:0]     dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    // Maximal-length Fibonacci tap masks; bit k set means stage k+1 is tapped.
    function automatic logic [15:0] tap_mask(input int width);
        logic [15:0] m;
        case (width)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h00B8;
        endcase
        return m;
    endfunction

    localparam logic [0:0]   ST_IDLE   = 1'b0;
    localparam logic [0:0]   ST_RUN    = 1'b1;
    localparam logic [W-1:0] CNT_LAST  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [15:0]  TAPS_ALL  = tap_mask(W);
    localparam logic [W-1:0] TAPS      = TAPS_ALL[W-1:0];
    localparam logic [W-1:0] SEED_W    = W'(SEED);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [W-1:0] SEED_EFF  = (SEED_W == '0) ? CNT_ONE : SEED_W;

    logic [0:0]     state;
    logic [W-1:0]   cnt;
    logic [W-1:0]   lfsr;
    logic [N*W-1:0] value_q;
    logic [W-1:0]   cnt_rev;
    logic [W-1:0]   rnd;
    logic           run;
    logic           advance;
    logic           accept;

    assign run     = (state == ST_RUN);
    assign advance = run & en;
    assign accept  = (state == ST_IDLE) & start;

    // Frame control. cnt wraps naturally from all-ones back to zero, so the
    // last valid bit is identified by cnt == all-ones while advancing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            value_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        value_q <= value;
                        cnt     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // LFSR reloads its seed on every accepted start so frames are repeatable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED_EFF;
        end else if (accept) begin
            lfsr <= SEED_EFF;
        end else if (advance) begin
            lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS)};
        end
    end

    // Bit-reversed counter visits every W-bit value once per frame with low
    // discrepancy, giving an exact ones count per channel.
    always_comb begin
        cnt_rev = '0;
        for (int b = 0; b < W; b++) begin
            cnt_rev[b] = cnt[W-1-b];
        end
    end

    always_comb begin
        rnd = cnt_rev;
        if (RNG_MODE != 0) begin
            rnd = lfsr;
        end
    end

    // All channels compare against the same rnd; the correlation is intended.
    genvar i;
    for (i = 0; i < N; i++) begin : g_ch
        assign dout[i] = advance & (value_q[i*W +: W] > rnd);
    end

    assign dout_valid = advance;
    assign busy       = run;

endmodule
`default_nettype wire

// File: tb/tb_sc_bitstream_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sc_bitstream_encoder
//  Description : Self-checking bench for sc_bitstream_encoder. One instance
//                in bit-reversed counter mode, one in LFSR mode; N=4, W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_bitstream_encoder;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int FRAME = 256;

    logic           clk    = 1'b0;
    logic           reset  = 1'b1;
    logic           start0 = 1'b0;
    logic           start1 = 1'b0;
    logic [N*W-1:0] value0 = '0;
    logic [N*W-1:0] value1 = '0;
    logic           en     = 1'b1;

    logic [N-1:0]   dout0, dout1;
    logic           valid0, valid1, busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    sc_bitstream_encoder #(.N(N), .W(W), .RNG_MODE(0), .SEED(1)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .start      (start0),
        .value      (value0),
        .en         (en),
        .dout       (dout0),
        .dout_valid (valid0),
        .busy       (busy0),
        .done       (done0)
    );

    sc_bitstream_encoder #(.N(N), .W(W), .RNG_MODE(1), .SEED(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .value      (value1),
        .en         (en),
        .dout       (dout1),
        .dout_valid (valid1),
        .busy       (busy1),
        .done       (done1)
    );

    int           tests = 0;
    int           fails = 0;
    logic [N-1:0] sb_q[$];

    int           ones[N];
    int           valid_cyc;
    int           busy_cyc;
    int           done_at;
    logic [3:0]   first4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = x[7-b];
        return r;
    endfunction

    // Expected dout word for each of the 2^W valid cycles of a counter-mode frame.
    task automatic push_frame(input logic [N*W-1:0] vals);
        logic [N-1:0] e;
        logic [7:0]   k8;
        for (int k = 0; k < FRAME; k++) begin
            k8 = 8'(k);
            for (int c = 0; c < N; c++) e[c] = (vals[c*W +: W] > rev8(k8));
            sb_q.push_back(e);
        end
    endtask

    task automatic run_frame(input logic [N*W-1:0] vals, input int stall_at, input int stall_len,
                             input bit hold_start, input logic [N*W-1:0] alt_vals);
        int cyc;
        bit fin;
        for (int c = 0; c < N; c++) ones[c] = 0;
        valid_cyc = 0; busy_cyc = 0; done_at = 0; first4 = '0;
        @(posedge clk); #1;
        value0 = vals;
        start0 = 1'b1;
        push_frame(vals);
        @(posedge clk); #1;
        start0 = hold_start;
        cyc = 1;
        fin = 1'b0;
        while (!fin) begin
            en = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (hold_start && cyc >= 20) value0 = alt_vals;
            @(negedge clk);
            if (done_at != 0) begin
                check("done_single_pulse", done0, 1'b0);
                check("busy_after_done", busy0, hold_start);
                fin = 1'b1;
            end else begin
                if (busy0) busy_cyc++;
                check("valid_vs_en", valid0, busy0 & en);
                if (valid0) begin
                    valid_cyc++;
                    if (valid_cyc <= 4) first4[valid_cyc-1] = dout0[0];
                    for (int c = 0; c < N; c++) ones[c] += dout0[c];
                    if (sb_q.size() == 0) check("sb_underflow", 1, 0);
                    else check("dout", dout0, sb_q.pop_front());
                end else begin
                    check("dout_idle", dout0, '0);
                end
                if (done0) done_at = cyc;
                if (cyc >= 600) begin
                    check("frame_timeout", 1, 0);
                    fin = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        en = 1'b1;
    endtask

    task automatic check_frame(input logic [N*W-1:0] vals, input int exp_done_at, input int exp_busy);
        check("valid_count", valid_cyc, FRAME);
        check("busy_count", busy_cyc, exp_busy);
        check("done_cycle", done_at, exp_done_at);
        for (int c = 0; c < N; c++) check($sformatf("ones_ch%0d", c), ones[c], 32'(vals[c*W +: W]));
        check("sb_empty", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic run_lfsr(output logic [FRAME-1:0] bits, output int nvalid, output int nones,
                            output int dat);
        @(posedge clk); #1;
        value1 = {N{8'd64}};
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        en = 1'b1;
        nvalid = 0; nones = 0; dat = 0; bits = '0;
        for (int cyc = 1; cyc <= 400 && dat == 0; cyc++) begin
            @(negedge clk);
            if (valid1) begin
                if (nvalid < FRAME) bits[nvalid] = dout1[0];
                nvalid++;
                nones += int'(dout1[0]);
            end
            if (done1) dat = cyc;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0]   v;
        logic [FRAME-1:0] bits_a, bits_b;
        int               nv, no, dat, diffs;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_valid", valid0, 1'b0);
        check("rst_dout", dout0, '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Exact counts, no stall
        v = {8'd37, 8'd128, 8'd255, 8'd0};
        run_frame(v, 1000, 0, 1'b0, '0);
        check_frame(v, 257, 256);

        // Bit order and a 10-cycle stall mid-frame
        v = {8'd100, 8'd254, 8'd1, 8'd128};
        run_frame(v, 50, 10, 1'b0, '0);
        check_frame(v, 267, 266);
        check("bit_order_ch0", first4, 4'b0101);

        // Start held through RUN with value changing; back-to-back restart at done
        v = {8'd17, 8'd200, 8'd64, 8'd3};
        run_frame(v, 1000, 0, 1'b1, {8'd250, 8'd1, 8'd7, 8'd99});
        check_frame(v, 257, 256);
        start0 = 1'b0;

        // Asynchronous reset around bit 100 of the follow-on frame
        repeat (98) @(posedge clk);
        #3;
        check("busy_before_rst", busy0, 1'b1);
        reset = 1'b0;
        #1;
        check("arst_busy", busy0, 1'b0);
        check("arst_valid", valid0, 1'b0);
        check("arst_dout", dout0, '0);
        check("arst_done", done0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_done", done0, 1'b0);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_done", done0, 1'b0);
        end

        // Full frame after the aborted one
        v = {8'd10, 8'd20, 8'd30, 8'd40};
        run_frame(v, 1000, 0, 1'b0, '0);
        check_frame(v, 257, 256);

        // LFSR mode: approximate count, repeatable across starts
        run_lfsr(bits_a, nv, no, dat);
        check("lfsr_valid_count", nv, FRAME);
        check("lfsr_done_cycle", dat, 257);
        check("lfsr_ones_in_63_65", (no >= 63 && no <= 65), 1);
        run_lfsr(bits_b, nv, no, dat);
        check("lfsr2_valid_count", nv, FRAME);
        diffs = 0;
        for (int k = 0; k < FRAME; k++) if (bits_a[k] !== bits_b[k]) diffs++;
        check("lfsr_repeat_diffs", diffs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
